// File: rtl/morra_match_ctrl.sv
// Match controller for the morra game engine: collects two player moves per round,
// issues them to the engine, tallies round outcomes and decides match end or abort.
module morra_match_ctrl #(
    parameter int unsigned MAX_REJECT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cfg_extra,
    input  logic       ack,
    input  logic       p1_valid,
    input  logic [1:0] p1_move,
    output logic       p1_ready,
    input  logic       p2_valid,
    input  logic [1:0] p2_move,
    output logic       p2_ready,
    output logic       eng_reset,
    output logic [1:0] eng_primo,
    output logic [1:0] eng_secondo,
    input  logic [1:0] eng_manche,
    input  logic [1:0] eng_partita,
    output logic       busy,
    output logic [4:0] round_cnt,
    output logic [3:0] p1_wins,
    output logic [3:0] p2_wins,
    output logic [3:0] draws,
    output logic       match_done,
    output logic [1:0] match_result,
    output logic       abort
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CFG     = 3'd1;
    localparam logic [2:0] COLLECT = 3'd2;
    localparam logic [2:0] ISSUE   = 3'd3;
    localparam logic [2:0] RESULT  = 3'd4;
    localparam logic [2:0] CHECK   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam logic [3:0] REJ_LIMIT = 4'(MAX_REJECT);

    logic [2:0] state, state_n;
    logic       p1_have, p1_have_n, p2_have, p2_have_n;
    logic [1:0] p1_lat, p1_lat_n, p2_lat, p2_lat_n;
    logic [3:0] rej_cnt, rej_cnt_n;
    logic [4:0] round_cnt_n;
    logic [3:0] p1_wins_n, p2_wins_n, draws_n;
    logic [1:0] match_result_n;
    logic       abort_n;
    logic       p1_ready_n, p2_ready_n, eng_reset_n, busy_n, match_done_n;
    logic [1:0] eng_primo_n, eng_secondo_n;
    logic       p1_xfer, p2_xfer;

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [4:0] sat5(input logic [4:0] v);
        return (v == 5'h1F) ? v : v + 5'd1;
    endfunction

    assign p1_xfer = p1_valid & p1_ready;
    assign p2_xfer = p2_valid & p2_ready;

    always_comb begin
        state_n        = state;
        p1_have_n      = p1_have;
        p2_have_n      = p2_have;
        p1_lat_n       = p1_lat;
        p2_lat_n       = p2_lat;
        rej_cnt_n      = rej_cnt;
        round_cnt_n    = round_cnt;
        p1_wins_n      = p1_wins;
        p2_wins_n      = p2_wins;
        draws_n        = draws;
        match_result_n = match_result;
        abort_n        = abort;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n        = CFG;
                    p1_have_n      = 1'b0;
                    p2_have_n      = 1'b0;
                    p1_lat_n       = '0;
                    p2_lat_n       = '0;
                    rej_cnt_n      = '0;
                    round_cnt_n    = '0;
                    p1_wins_n      = '0;
                    p2_wins_n      = '0;
                    draws_n        = '0;
                    match_result_n = '0;
                    abort_n        = 1'b0;
                end
            end
            CFG: begin
                state_n   = COLLECT;
                p1_have_n = 1'b0;
                p2_have_n = 1'b0;
            end
            COLLECT: begin
                if (p1_xfer) begin
                    p1_have_n = 1'b1;
                    p1_lat_n  = p1_move;
                end
                if (p2_xfer) begin
                    p2_have_n = 1'b1;
                    p2_lat_n  = p2_move;
                end
                if (p1_have_n && p2_have_n)
                    state_n = ISSUE;
            end
            ISSUE: state_n = RESULT;
            RESULT: begin
                state_n = CHECK;
                case (eng_manche)
                    2'b01: p1_wins_n = sat4(p1_wins);
                    2'b10: p2_wins_n = sat4(p2_wins);
                    2'b11: draws_n   = sat4(draws);
                    default: ;
                endcase
                if (eng_manche == 2'b00) begin
                    rej_cnt_n = sat4(rej_cnt);
                end else begin
                    rej_cnt_n   = '0;
                    round_cnt_n = sat5(round_cnt);
                end
            end
            CHECK: begin
                if (eng_partita != 2'b00) begin
                    match_result_n = eng_partita;
                    state_n        = DONE;
                end else if (rej_cnt == REJ_LIMIT) begin
                    abort_n        = 1'b1;
                    match_result_n = '0;
                    state_n        = DONE;
                end else begin
                    state_n   = COLLECT;
                    p1_have_n = 1'b0;
                    p2_have_n = 1'b0;
                end
            end
            DONE: begin
                if (ack) begin
                    state_n = IDLE;
                    abort_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so they register in step with it.
        busy_n        = (state_n != IDLE);
        eng_reset_n   = (state_n == CFG);
        eng_primo_n   = (state_n == CFG) ? cfg_extra[3:2] : (state_n == ISSUE) ? p1_lat_n : 2'b00;
        eng_secondo_n = (state_n == CFG) ? cfg_extra[1:0] : (state_n == ISSUE) ? p2_lat_n : 2'b00;
        p1_ready_n    = (state_n == COLLECT) && !p1_have_n;
        p2_ready_n    = (state_n == COLLECT) && !p2_have_n;
        match_done_n  = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            p1_have      <= 1'b0;
            p2_have      <= 1'b0;
            p1_lat       <= '0;
            p2_lat       <= '0;
            rej_cnt      <= '0;
            round_cnt    <= '0;
            p1_wins      <= '0;
            p2_wins      <= '0;
            draws        <= '0;
            match_result <= '0;
            abort        <= 1'b0;
            busy         <= 1'b0;
            eng_reset    <= 1'b1;
            eng_primo    <= '0;
            eng_secondo  <= '0;
            p1_ready     <= 1'b0;
            p2_ready     <= 1'b0;
            match_done   <= 1'b0;
        end else begin
            state        <= state_n;
            p1_have      <= p1_have_n;
            p2_have      <= p2_have_n;
            p1_lat       <= p1_lat_n;
            p2_lat       <= p2_lat_n;
            rej_cnt      <= rej_cnt_n;
            round_cnt    <= round_cnt_n;
            p1_wins      <= p1_wins_n;
            p2_wins      <= p2_wins_n;
            draws        <= draws_n;
            match_result <= match_result_n;
            abort        <= abort_n;
            busy         <= busy_n;
            eng_reset    <= eng_reset_n;
            eng_primo    <= eng_primo_n;
            eng_secondo  <= eng_secondo_n;
            p1_ready     <= p1_ready_n;
            p2_ready     <= p2_ready_n;
            match_done   <= match_done_n;
        end
    end

endmodule

// File: tb/tb_morra_match_ctrl.sv
// Directed bench for morra_match_ctrl with a tiny engine model that answers each
// issued round with a planned manche/partita pair.
module tb_morra_match_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, ack;
    logic [3:0] cfg_extra;
    logic       p1_valid, p2_valid, p1_ready, p2_ready;
    logic [1:0] p1_move, p2_move;
    logic       eng_reset;
    logic [1:0] eng_primo, eng_secondo;
    logic [1:0] eng_manche = 2'b00;
    logic [1:0] eng_partita = 2'b00;
    logic       busy, match_done, abort;
    logic [4:0] round_cnt;
    logic [3:0] p1_wins, p2_wins, draws;
    logic [1:0] match_result;

    logic [1:0] plan_manche = 2'b00;
    logic [1:0] plan_partita = 2'b00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    morra_match_ctrl #(.MAX_REJECT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_extra(cfg_extra), .ack(ack),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .eng_reset(eng_reset), .eng_primo(eng_primo), .eng_secondo(eng_secondo),
        .eng_manche(eng_manche), .eng_partita(eng_partita),
        .busy(busy), .round_cnt(round_cnt), .p1_wins(p1_wins), .p2_wins(p2_wins),
        .draws(draws), .match_done(match_done), .match_result(match_result), .abort(abort)
    );

    // Engine model: a non-idle move pair outside engine reset is a round issue.
    always @(posedge clk) begin
        if (eng_reset) begin
            eng_manche  <= 2'b00;
            eng_partita <= 2'b00;
        end else if (eng_primo != 2'b00 || eng_secondo != 2'b00) begin
            eng_manche  <= plan_manche;
            eng_partita <= plan_partita;
        end else begin
            eng_manche  <= 2'b00;
        end
    end

    typedef struct {
        bit         first;
        logic [1:0] m1, m2, manche, partita;
        int         e_p1, e_p2, e_dr, e_rc, e_done, e_res;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (p1_ready && p2_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic do_start(input logic [3:0] cfg);
        start = 1'b1;
        cfg_extra = cfg;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_done_clear", 32'(match_done), 32'd0);
        chk("ack_abort_clear", 32'(abort), 32'd0);
        chk("ack_idle", 32'(busy), 32'd0);
    endtask

    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2,
                              input logic [1:0] manche, input logic [1:0] partita);
        bit ok = 1'b0;
        wait_ready("round_ready_wait");
        plan_manche  = manche;
        plan_partita = partita;
        p1_valid = 1'b1; p1_move = m1;
        p2_valid = 1'b1; p2_move = m2;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if ((p1_ready && p2_ready) || match_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("round_end_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ack = 1'b0; cfg_extra = 4'b0000;
        p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;

        vecs[0] = '{1'b1, 2'b01, 2'b11, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0};
        vecs[1] = '{1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 2, 0, 0, 2, 0, 0};
        vecs[2] = '{1'b0, 2'b11, 2'b10, 2'b01, 2'b00, 3, 0, 0, 3, 0, 0};
        vecs[3] = '{1'b0, 2'b01, 2'b11, 2'b01, 2'b01, 4, 0, 0, 4, 1, 1};
        vecs[4] = '{1'b1, 2'b10, 2'b01, 2'b10, 2'b00, 0, 1, 0, 1, 0, 0};
        vecs[5] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 1, 1, 2, 0, 0};
        vecs[6] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1, 1, 2, 0, 0};
        vecs[7] = '{1'b0, 2'b01, 2'b10, 2'b01, 2'b00, 1, 1, 1, 3, 0, 0};
        vecs[8] = '{1'b0, 2'b10, 2'b11, 2'b10, 2'b10, 1, 2, 1, 4, 1, 2};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_eng_reset", 32'(eng_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({p1_ready, p2_ready}), 32'd0);
        chk("rst_done", 32'({match_done, abort, match_result}), 32'd0);
        chk("rst_cnt", 32'({round_cnt, p1_wins, p2_wins, draws}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_eng_reset", 32'(eng_reset), 32'd0);
        chk("rel_eng_moves", 32'({eng_primo, eng_secondo}), 32'd0);

        // Configuration cycle
        start = 1'b1; cfg_extra = 4'b1011;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_eng_reset", 32'(eng_reset), 32'd1);
        chk("cfg_primo", 32'(eng_primo), 32'd2);
        chk("cfg_secondo", 32'(eng_secondo), 32'd3);
        chk("cfg_busy", 32'(busy), 32'd1);
        chk("cfg_ready", 32'({p1_ready, p2_ready}), 32'd0);
        @(negedge clk);
        chk("col_eng_reset", 32'(eng_reset), 32'd0);
        chk("col_eng_moves", 32'({eng_primo, eng_secondo}), 32'd0);
        chk("col_ready", 32'({p1_ready, p2_ready}), 32'd3);

        // Staggered handshakes: P1 at t, P2 at t+3
        plan_manche = 2'b10; plan_partita = 2'b00;
        p1_valid = 1'b1; p1_move = 2'b10;
        @(negedge clk);
        p1_valid = 1'b0;
        chk("stag_p1_ready_low", 32'(p1_ready), 32'd0);
        chk("stag_p2_ready_high", 32'(p2_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("stag_no_issue", 32'({eng_primo, eng_secondo}), 32'd0);
        p2_valid = 1'b1; p2_move = 2'b01;
        @(negedge clk);
        p2_valid = 1'b0;
        chk("issue_primo", 32'(eng_primo), 32'd2);
        chk("issue_secondo", 32'(eng_secondo), 32'd1);
        chk("issue_ready", 32'({p1_ready, p2_ready}), 32'd0);
        @(negedge clk);
        chk("issue_one_cycle", 32'({eng_primo, eng_secondo}), 32'd0);
        @(negedge clk);
        chk("check_ready_low", 32'({p1_ready, p2_ready}), 32'd0);
        @(negedge clk);
        chk("lat_ready_again", 32'({p1_ready, p2_ready}), 32'd3);
        chk("lat_p2_wins", 32'(p2_wins), 32'd1);
        chk("lat_round_cnt", 32'(round_cnt), 32'd1);

        // Reset during RESULT
        plan_manche = 2'b01;
        p1_valid = 1'b1; p1_move = 2'b11;
        p2_valid = 1'b1; p2_move = 2'b10;
        @(negedge clk);
        p1_valid = 1'b0; p2_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("amid_eng_reset", 32'(eng_reset), 32'd1);
        chk("amid_busy", 32'(busy), 32'd0);
        chk("amid_cnt", 32'({round_cnt, p1_wins, p2_wins, draws}), 32'd0);
        chk("amid_ready", 32'({p1_ready, p2_ready, eng_primo, eng_secondo}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("amid_rel", 32'({eng_reset, busy, eng_primo, eng_secondo}), 32'd0);
        do_start(4'b0000);
        play_round(2'b01, 2'b10, 2'b10, 2'b00);
        chk("clean_cnt", 32'({round_cnt, p1_wins, p2_wins, draws}), {19'd0, 5'd1, 4'd0, 4'd1, 4'd0});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven matches
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].first) begin
                if (match_done) do_ack();
                do_start(4'b0000);
            end
            play_round(vecs[i].m1, vecs[i].m2, vecs[i].manche, vecs[i].partita);
            chk($sformatf("v%0d_p1_wins", i), 32'(p1_wins), 32'(vecs[i].e_p1));
            chk($sformatf("v%0d_p2_wins", i), 32'(p2_wins), 32'(vecs[i].e_p2));
            chk($sformatf("v%0d_draws", i), 32'(draws), 32'(vecs[i].e_dr));
            chk($sformatf("v%0d_round_cnt", i), 32'(round_cnt), 32'(vecs[i].e_rc));
            chk($sformatf("v%0d_done", i), 32'(match_done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_result", i), 32'(match_result), 32'(vecs[i].e_res));
        end

        // DONE holds against start while ack is low
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done", 32'({match_done, busy, abort}), 32'd6);
        end
        chk("hold_cnt", 32'({round_cnt, p1_wins, p2_wins, draws, match_result}),
            {11'd0, 5'd4, 4'd1, 4'd2, 4'd1, 2'd2});
        start = 1'b0;
        do_ack();

        // Pure rejects abort the match
        do_start(4'b0000);
        for (int i = 0; i < 8; i++) begin
            play_round(2'b01, 2'b01, 2'b00, 2'b00);
            if (i < 7) chk("rej_not_done", 32'(match_done), 32'd0);
        end
        chk("rej_abort", 32'({match_done, abort}), 32'd3);
        chk("rej_result", 32'(match_result), 32'd0);
        chk("rej_round_cnt", 32'(round_cnt), 32'd0);
        do_ack();

        // An accepted round clears the reject run
        do_start(4'b0000);
        for (int i = 0; i < 3; i++) play_round(2'b10, 2'b10, 2'b00, 2'b00);
        play_round(2'b10, 2'b01, 2'b11, 2'b00);
        for (int i = 0; i < 8; i++) begin
            play_round(2'b11, 2'b11, 2'b00, 2'b00);
            if (i < 7) chk("rej2_not_done", 32'(match_done), 32'd0);
        end
        chk("rej2_abort", 32'({match_done, abort}), 32'd3);
        chk("rej2_cnt", 32'({round_cnt, draws}), {23'd0, 5'd1, 4'd1});
        do_ack();

        // Saturation
        do_start(4'b0000);
        for (int i = 0; i < 20; i++) play_round(2'b01, 2'b10, 2'b01, 2'b00);
        chk("sat_p1_wins", 32'(p1_wins), 32'd15);
        chk("sat_rc20", 32'(round_cnt), 32'd20);
        for (int i = 0; i < 15; i++) play_round(2'b10, 2'b01, 2'b11, (i == 14) ? 2'b11 : 2'b00);
        chk("sat_draws", 32'(draws), 32'd15);
        chk("sat_round_cnt", 32'(round_cnt), 32'd31);
        chk("sat_result", 32'({match_done, match_result}), 32'd7);
        do_ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morra_match_ctrl.md
MORRA_MATCH_CTRL -- requirements
Module: morra_match_ctrl

Interface
REQ-001 SHALL have parameter MAX_REJECT, default 8: consecutive rejected rounds (engine manche 00) that abort a match, range 1-15.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: start  in  1  begin match (sampled in IDLE); cfg_extra  in  4  extra rounds {primo,secondo} loaded into engine at configuration; ack  in  1  clears DONE.
REQ-004 SHALL have ports: p1_valid  in  1; p1_move  in  2; p1_ready  out  1; p2_valid  in  1; p2_move  in  2; p2_ready  out  1 (per-player move handshakes).
REQ-005 SHALL have ports: eng_reset  out  1; eng_primo  out  2; eng_secondo  out  2; eng_manche  in  2; eng_partita  in  2 (game-engine connection).
REQ-006 SHALL have ports: busy  out  1; round_cnt  out  5; p1_wins  out  4; p2_wins  out  4; draws  out  4; match_done  out  1; match_result  out  2; abort  out  1.

Function
REQ-007 SHALL implement states IDLE, CFG, COLLECT, ISSUE, RESULT, CHECK, DONE, all outputs registered.
REQ-008 IDLE: start=1 -> CFG next cycle; counters cleared on that transition; busy=0 only in IDLE.
REQ-009 CFG lasts exactly one cycle: eng_reset=1, eng_primo=cfg_extra[3:2], eng_secondo=cfg_extra[1:0]; then COLLECT.
REQ-010 Outside CFG and ISSUE, eng_reset=0 and eng_primo=eng_secondo=00 (engine idle code).
REQ-011 COLLECT: pN_ready=1 while player N's move not yet latched; transfer on pN_valid&pN_ready; ready drops the cycle after transfer.
REQ-012 Both players may transfer in the same cycle; each is latched independently; moves of 00 are latched unchanged (engine rejects them).
REQ-013 When both moves latched -> ISSUE; ISSUE lasts one cycle driving latched moves on eng_primo/eng_secondo; pN_ready=0 outside COLLECT.
REQ-014 RESULT (one cycle after ISSUE): sample eng_manche: 01 -> p1_wins+1, round_cnt+1; 10 -> p2_wins+1, round_cnt+1; 11 -> draws+1, round_cnt+1; 00 -> reject counter+1.
REQ-015 Any accepted round (manche != 00) SHALL clear the reject counter.
REQ-016 CHECK (one cycle after RESULT): eng_partita != 00 -> match_result=eng_partita, DONE; else reject counter == MAX_REJECT -> abort=1, match_result=00, DONE; else COLLECT with latches cleared.
REQ-017 Counters SHALL saturate (round_cnt at 31, others at 15), never wrap.
REQ-018 DONE: match_done=1, counters, match_result and abort held; ack=1 -> IDLE next cycle, match_done and abort cleared; start ignored in DONE.
REQ-019 ack outside DONE and start outside IDLE SHALL be ignored.
REQ-020 Round latency: both moves transferred in cycle t -> ISSUE t+1, RESULT t+2, CHECK t+3, COLLECT ready again t+4.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE, all counters/latches 0, p1_ready=p2_ready=0, eng_reset=1, eng_primo=eng_secondo=00, busy=0, match_done=0, abort=0, match_result=00.
REQ-022 After reset release eng_reset SHALL be 0 from the first clock edge; reset mid-match discards latched moves with no further engine issue.

Verification
REQ-023 start, cfg_extra=0000, P1 plays 01,10,11,01 vs P2 11,01,10,11 (all P1 wins, no repeats), engine partita=01 after round 4 -> match_done=1, match_result=01, p1_wins=4, round_cnt=4.
REQ-024 P1 valid at cycle t, P2 valid at t+3 -> p1_ready low from t+1, ISSUE at t+4, eng_primo/secondo equal latched moves for exactly one cycle.
REQ-025 MAX_REJECT=8, both players repeat the same move so engine returns manche 00 eight times -> abort=1, match_result=00, round_cnt=0, DONE.
REQ-026 start with cfg_extra=1011 -> single-cycle eng_reset=1 with eng_primo=10, eng_secondo=11, then COLLECT with both readies high.
REQ-027 reset asserted during RESULT -> outputs at reset values immediately without clock; next start runs clean match with counters from 0.
REQ-028 In DONE, hold ack=0 for 10 cycles with start=1 -> state and outputs unchanged; ack=1 -> IDLE next cycle, match_done=0.
